// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline sequencer for stalls, flushes, memory waits and halt drain.
// Control outputs are combinational from state and inputs; state and counters are registered.
module pipe_ctrl #(
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_re1,
   input  logic             id_re2,
   input  logic [4:0]       ex_wR,
   input  logic             ex_rf_we,
   input  logic             ex_is_load,
   input  logic             ex_br_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int DW = $clog2(DRAIN_CYCLES) + 1;
   typedef enum logic [1:0] {RUN, WAIT, DRAIN, HALTED} state_t;
   state_t        state, state_nx;
   logic [DW-1:0] drain, drain_nx;
   logic          memwait, lu, freeze, stall_inc, flush_inc;
   assign memwait = mem_req & ~mem_ready;
   assign lu = ex_is_load & ex_rf_we & (ex_wR != 5'd0) &
               ((id_re1 & (id_rs1 == ex_wR)) | (id_re2 & (id_rs2 == ex_wR)));
   assign halted = (state == HALTED);
   always_comb begin
      state_nx     = state;
      drain_nx     = drain;
      freeze       = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      case (state)
         RUN:
            if (memwait) begin
               freeze    = 1'b1;
               stall_inc = 1'b1;
               state_nx  = WAIT;
            end else if (ex_br_taken) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               flush_inc  = 1'b1;
            end else if (halt_req) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
               drain_nx   = DW'(DRAIN_CYCLES - 1);
               state_nx   = DRAIN;
            end else if (lu) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
               stall_inc  = 1'b1;
            end
         WAIT:
            if (!mem_ready) begin
               freeze    = 1'b1;
               stall_inc = 1'b1;
            end else state_nx = RUN;
         DRAIN: begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            if (memwait) begin
               freeze    = 1'b1;
               stall_inc = 1'b1;
            end else begin
               drain_nx = drain - DW'(drain != '0);
               state_nx = (drain <= DW'(1)) ? HALTED : DRAIN;
            end
         end
         HALTED: freeze = 1'b1;
      endcase
      // a frozen pipeline holds every stage and keeps MEM/WB from committing
      if (freeze) {pc_en, ifid_en, idex_en, exmem_en, memwb_bubble} = 5'b00001;
      if (!rst) {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble} = 7'b0000001;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= RUN;
         drain     <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nx;
         drain <= drain_nx;
         if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed checks of pipe_ctrl against a behavioural model.
// Two instances share stimulus: full-width counters and 4-bit counters that must saturate.
module tb_pipe_ctrl;
   localparam int D = 4;
   localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALTED = 3;
   logic clk = 1'b0, rst = 1'b0;
   logic [4:0] id_rs1, id_rs2, ex_wR;
   logic id_re1, id_re2, ex_rf_we, ex_is_load, ex_br_taken, mem_req, mem_ready, halt_req;
   logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, halted;
   logic pc_en4, ifid_en4, idex_en4, exmem_en4, ifid_flush4, idex_flush4, memwb_bubble4, halted4;
   logic [31:0] stall_cnt, flush_cnt;
   logic [3:0] stall_cnt4, flush_cnt4;
   int checks = 0, failures = 0;
   int mode = M_RUN, drain_left = 0;
   longint m_stall = 0, m_flush = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.CNT_W(32), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
      .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .pc_en(pc_en),
      .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .memwb_bubble(memwb_bubble), .halted(halted),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   pipe_ctrl #(.CNT_W(4), .DRAIN_CYCLES(D)) dut4 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
      .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .pc_en(pc_en4),
      .ifid_en(ifid_en4), .idex_en(idex_en4), .exmem_en(exmem_en4), .ifid_flush(ifid_flush4),
      .idex_flush(idex_flush4), .memwb_bubble(memwb_bubble4), .halted(halted4),
      .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Model: expected controls derived from which event wins this cycle
   always @(negedge clk) begin
      logic mw, lu, run, frz, br, hlt, lus, stop;
      logic [7:0] ev;
      if (!rst) begin
         ev = 8'b0000_0010;
         mode = M_RUN; drain_left = 0; m_stall = 0; m_flush = 0;
      end else begin
         mw   = mem_req && !mem_ready;
         lu   = ex_is_load && ex_rf_we && ex_wR != 0 &&
                ((id_re1 && id_rs1 == ex_wR) || (id_re2 && id_rs2 == ex_wR));
         run  = mode == M_RUN;
         stop = mode == M_HALTED;
         frz  = (run && mw) || (mode == M_WAIT && !mem_ready) || (mode == M_DRAIN && mw);
         br   = run && !mw && ex_br_taken;
         hlt  = run && !mw && !ex_br_taken && halt_req;
         lus  = run && !mw && !ex_br_taken && !halt_req && lu;
         ev = {!(frz || hlt || lus || mode == M_DRAIN || stop), !(frz || lus || stop),
               !(frz || stop), !(frz || stop), br || hlt || mode == M_DRAIN, br || lus,
               frz || stop, stop};
      end
      chk("ctrl32", {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, halted}, ev);
      chk("ctrl4", {pc_en4, ifid_en4, idex_en4, exmem_en4, ifid_flush4, idex_flush4, memwb_bubble4, halted4}, ev);
      chk("stall32", stall_cnt, m_stall);
      chk("flush32", flush_cnt, m_flush);
      chk("stall4", stall_cnt4, m_stall > 15 ? 15 : m_stall);
      chk("flush4", flush_cnt4, m_flush > 15 ? 15 : m_flush);
      if (rst) begin
         m_stall += (frz || lus) ? 1 : 0;
         m_flush += br ? 1 : 0;
         if (run && mw) mode = M_WAIT;
         else if (mode == M_WAIT && mem_ready) mode = M_RUN;
         else if (hlt) begin
            mode = M_DRAIN;
            drain_left = D > 1 ? D - 1 : 1;
         end else if (mode == M_DRAIN && !mw) begin
            drain_left--;
            if (drain_left == 0) mode = M_HALTED;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      {id_rs1, id_rs2, ex_wR} = '0;
      {id_re1, id_re2, ex_rf_we, ex_is_load, ex_br_taken, mem_req, mem_ready, halt_req} = '0;
   endtask

   task automatic rnd();
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_wR = 5'($urandom_range(0, 3));
      id_re1 = 1'($urandom_range(0, 1));
      id_re2 = 1'($urandom_range(0, 1));
      ex_rf_we = 1'($urandom_range(0, 1));
      ex_is_load = $urandom_range(0, 2) == 0;
      ex_br_taken = $urandom_range(0, 7) == 0;
      mem_req = $urandom_range(0, 3) == 0;
      mem_ready = 1'($urandom_range(0, 1));
      halt_req = $urandom_range(0, 39) == 0;
   endtask

   task automatic set_lu();
      ex_is_load = 1; ex_rf_we = 1; ex_wR = 5; id_rs2 = 5; id_re2 = 1; id_rs1 = 0; id_re1 = 0;
   endtask

   task automatic do_reset();
      step();
      rst = 0;
      clr();
      step();
      step();
      rst = 1;
   endtask

   task automatic halt_run(input bit with_wait, output int n);
      step();
      halt_req = 1;
      #2 n = (!pc_en && ifid_flush) ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         step();
         clr();
         if (with_wait && i == 0) begin mem_req = 1; mem_ready = 0; end
         #2;
         if (halted) break;
         n += (!pc_en && ifid_flush) ? 1 : 0;
      end
   endtask

   initial begin
      int n, nb, nf, fi;
      clr();
      do_reset();
      // load-use via rs2
      step(); set_lu();
      #2 chk("lu_ctrl", {pc_en, ifid_en, idex_flush}, 3'b001);
      step(); clr();
      #2 chk("lu_stall_cnt", stall_cnt, 1);
      chk("lu_after_default", {pc_en, ifid_en, idex_flush}, 3'b110);
      step(); set_lu(); ex_wR = 0; id_rs2 = 0;
      #2 chk("lu_x0_nostall", pc_en, 1);
      step(); set_lu(); id_re2 = 0;
      #2 chk("lu_nore_nostall", pc_en, 1);
      step(); clr();
      #2 chk("lu_nostall_cnt", stall_cnt, 1);
      // branch beats load-use and halt
      do_reset();
      step(); set_lu(); ex_br_taken = 1; halt_req = 1;
      #2 chk("br_ctrl", {ifid_flush, idex_flush, pc_en}, 3'b111);
      step(); clr();
      #2 chk("br_flush_cnt", flush_cnt, 1);
      chk("br_stall_cnt", stall_cnt, 0);
      chk("br_stays_run", {pc_en, ifid_flush, halted}, 3'b100);
      // memory wait with a held branch
      do_reset();
      nb = 0; nf = 0; fi = -1;
      for (int i = 0; i < 6; i++) begin
         step();
         ex_br_taken = i < 5; mem_req = i < 4; mem_ready = i == 3;
         #2 nb += memwb_bubble ? 1 : 0;
         if (ifid_flush && idex_flush) begin nf++; fi = i; end
      end
      step(); clr();
      #2 chk("mw_bubbles", nb, 3);
      chk("mw_flushes", nf, 1);
      chk("mw_flush_cycle", fi, 4);
      chk("mw_stall_cnt", stall_cnt, 3);
      // halt drain, plain and with one memory wait inside
      do_reset();
      halt_run(0, n);
      chk("halt_len", n, 4);
      chk("halted_outs", {halted, pc_en, ifid_en, idex_en, exmem_en, memwb_bubble}, 6'b100001);
      do_reset();
      halt_run(1, n);
      chk("halt_wait_len", n, 5);
      chk("halted_wait", halted, 1);
      // counter saturation at 4 bits
      do_reset();
      for (int i = 0; i < 20; i++) begin step(); set_lu(); end
      step(); clr();
      #2 chk("sat_stall4", stall_cnt4, 15);
      chk("sat_stall32", stall_cnt, 20);
      // asynchronous reset in the middle of a drain
      do_reset();
      step(); set_lu();
      step(); clr(); halt_req = 1;
      step(); halt_req = 0;
      step();
      #2 rst = 0;
      #1 chk("ar_halted", halted, 0);
      chk("ar_stall", stall_cnt, 0);
      chk("ar_flush", flush_cnt, 0);
      chk("ar_outs", {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}, 7'b0000001);
      step(); rnd();
      #2 chk("ar_hold", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
      step(); rst = 1; clr();
      #2 chk("ar_release", {pc_en, halted}, 2'b10);
      // randomized traffic with occasional resets to leave HALTED
      for (int i = 0; i < 3000; i++) begin
         step();
         rst = $urandom_range(0, 149) != 0;
         rnd();
      end
      step(); rst = 1; clr();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
